indata_reorder: RTL and testbench
=================================

// Module: indata_reorder
// PURPOSE
//  Frame buffer for the TI-ROIC input path. Captures one frame of BUFFER_DEPTH
//  data words as they arrive on a valid_in strobe. On a read_req pulse it
//  replays the frame as a contiguous burst, in the order the words were written.
//  Decouples ROIC sample arrival from downstream readout timing.
// PARAMETERS
//  DATA_WIDTH    24   width of each data word
//  BUFFER_DEPTH  256  words per frame; power of two, >= 2
// PORTS
//  clk        in   1           system clock; all logic on rising edge
//  rst        in   1           synchronous, active-high reset
//  read_req   in   1           single-cycle request to start frame readout
//  data_in    in   DATA_WIDTH  input word, sampled when valid_in=1
//  valid_in   in   1           data_in qualifier
//  data_out   out  DATA_WIDTH  readout word
//  valid_out  out  1           data_out qualifier
// BEHAVIOUR
//  - Storage: BUFFER_DEPTH x DATA_WIDTH synchronous RAM.
//    wr_ptr and rd_ptr are each $clog2(BUFFER_DEPTH) bits wide.
//    The frame counter has one extra bit.
//  - Reset (rst=1 at an edge):
//    state=FILL, wr_ptr=0, rd_ptr=0, count=0, valid_out=0, data_out=0.
//    RAM contents are not cleared.
//    A reset mid-burst aborts the burst immediately.
//  - States: FILL, READY, READ.
//  - FILL:
//    - Each edge with valid_in=1 writes data_in to mem[wr_ptr], then wr_ptr++ and count++.
//    - When the BUFFER_DEPTH-th word is written, go to READY.
//    - read_req in FILL (partial frame) is ignored; no output.
//  - READY:
//    - valid_in is ignored (overflow words dropped, no wrap, no overwrite).
//    - read_req=1 at edge k: go to READ with rd_ptr=0.
//  - READ:
//    - After edge k+1: data_out=mem[0], valid_out=1.
//    - Word i appears after edge k+1+i; valid_out stays high for exactly
//      BUFFER_DEPTH consecutive cycles, with no gaps.
//    - Output order is identical to write order: index i out = i-th word written.
//    - valid_in is ignored (dropped). read_req is ignored (no restart).
//    - After the last word's cycle: valid_out=0, data_out=0, wr_ptr=0, count=0,
//      rd_ptr=0, state=FILL. The next frame may start writing the cycle after valid_out falls.
//  - data_out is 0 whenever valid_out=0.
//    Both outputs are registered; there is no combinational path from any input.
//  - Latency: read_req sampled -> first valid_out is 1 cycle.
//    Burst length is BUFFER_DEPTH cycles.
//  - Simultaneous valid_in and read_req when the last write completes the frame:
//    the write is taken and read_req is ignored; read_req must be re-issued in READY.
// TESTING
//  1. Reset 5 cycles; write 0..255 on consecutive cycles; idle 5; pulse read_req
//     -> 256 valid_out beats with data_out=0..255 in order, no gaps.
//  2. Write 100 words; pulse read_req -> valid_out stays 0.
//     Then write 156 more words and pulse read_req -> 256-word burst is correct.
//  3. Write 300 words (0..299) -> words 256..299 are dropped; readout = 0..255.
//  4. Two back-to-back frames (0..255, then 0x100..0x1FF after the first burst)
//     -> each burst matches its own frame.
//  5. Assert rst for one cycle at burst beat 50 -> valid_out=0 and data_out=0
//     the next cycle; a subsequent read_req is ignored until a new full frame is written.
//  6. read_req pulse during the burst and valid_in during the burst
//     -> burst unaffected (256 beats), and those valid_in words are not stored.

Source files
------------

// File: rtl/indata_reorder.sv
// Frame buffer: captures one BUFFER_DEPTH-word frame, then replays it in write
// order as a gap-free burst after a read request.
module indata_reorder #(
  parameter int unsigned DATA_WIDTH   = 24,
  parameter int unsigned BUFFER_DEPTH = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_req,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  valid_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  valid_out
);

  localparam int unsigned AW = $clog2(BUFFER_DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [1:0] S_FILL  = 2'd0;
  localparam logic [1:0] S_READY = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;

  logic [1:0]            state;
  logic [1:0]            next_state_c;
  logic                  wr_en_c;
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] mem [BUFFER_DEPTH];

  // Next-state logic; count doubles as the remaining-beat counter during READ.
  always_comb begin
    next_state_c = state;
    wr_en_c      = 1'b0;
    case (state)
      S_FILL: begin
        if (valid_in) begin
          wr_en_c = 1'b1;
          if (count == CW'(BUFFER_DEPTH - 1)) next_state_c = S_READY;
        end
      end
      S_READY: begin
        if (read_req) next_state_c = S_READ;
      end
      S_READ: begin
        if (count == '0) next_state_c = S_FILL;
      end
      default: next_state_c = S_FILL;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_FILL;
    else     state <= next_state_c;
  end

  // Frame storage; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_c && !rst) mem[wr_ptr] <= data_in;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
      data_out  <= '0;
    end else begin
      valid_out <= 1'b0;
      data_out  <= '0;
      case (state)
        S_FILL: begin
          if (wr_en_c) begin
            wr_ptr <= wr_ptr + AW'(1);
            count  <= count + CW'(1);
          end
        end
        S_READY: begin
          if (read_req) rd_ptr <= '0;
        end
        S_READ: begin
          if (count != '0) begin
            data_out  <= mem[rd_ptr];
            valid_out <= 1'b1;
            rd_ptr    <= rd_ptr + AW'(1);
            count     <= count - CW'(1);
          end else begin
            wr_ptr <= '0;
            rd_ptr <= '0;
          end
        end
        default: begin
          wr_ptr <= '0;
          rd_ptr <= '0;
          count  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_indata_reorder.sv
// Bench for indata_reorder: queue-based frame model checked every cycle, plus
// literal burst checks on timing, length and contents.
module tb_indata_reorder;

  localparam int DW    = 24;
  localparam int DEPTH = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          read_req = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] data_out;
  logic          valid_out;

  int n_cmp = 0;
  int n_bad = 0;

  indata_reorder #(.DATA_WIDTH(DW), .BUFFER_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .read_req (read_req),
    .data_in  (data_in),
    .valid_in (valid_in),
    .data_out (data_out),
    .valid_out(valid_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: a frame is a queue; once full it is frozen until replayed.
  logic [DW-1:0] mframe[$];
  bit            mfull    = 0;
  bit            mreading = 0;
  int            midx     = 0;
  logic          mexp_v   = 1'b0;
  logic [DW-1:0] mexp_d   = '0;
  bit            started  = 0;

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      mframe.delete();
      mfull = 0; mreading = 0; mexp_v = 1'b0; mexp_d = '0;
    end else if (mreading) begin
      if (midx < DEPTH) begin
        mexp_v = 1'b1; mexp_d = mframe[midx]; midx++;
      end else begin
        mexp_v = 1'b0; mexp_d = '0; mreading = 0; mfull = 0; mframe.delete();
      end
    end else if (mfull) begin
      mexp_v = 1'b0; mexp_d = '0;
      if (read_req) begin mreading = 1; midx = 0; end
    end else begin
      mexp_v = 1'b0; mexp_d = '0;
      if (valid_in) begin
        mframe.push_back(data_in);
        if (mframe.size() == DEPTH) mfull = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_valid_out", 32'(valid_out), 32'(mexp_v));
      chk("model_data_out", 32'(data_out), 32'(mexp_d));
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin @(posedge clk); #1; end
  endtask

  task automatic write_words(input int base, input int n, input bit req_on_last);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      valid_in = 1'b1;
      data_in  = DW'(base + i);
      read_req = (req_on_last && i == n - 1);
    end
    @(posedge clk); #1;
    valid_in = 1'b0;
    read_req = 1'b0;
  endtask

  task automatic pulse_req();
    @(posedge clk); #1; read_req = 1'b1;
    @(posedge clk); #1; read_req = 1'b0;
  endtask

  task automatic expect_idle(input string name, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      chk(name, 32'(valid_out), 32'd0);
    end
  endtask

  // Pulse read_req, then beat i must appear exactly i+1 edges after the sampling edge.
  // abort_at >= 0 applies a one-cycle reset at that beat; disturb injects traffic mid-burst.
  task automatic read_burst(input int base, input int abort_at, input bit disturb);
    int beats;
    beats = 0;
    pulse_req();
    for (int i = 0; i <= DEPTH; i++) begin
      @(posedge clk); #1;
      if (abort_at >= 0 && i == abort_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("abort_valid", 32'(valid_out), 32'd0);
        chk("abort_data", 32'(data_out), 32'd0);
        return;
      end
      if (disturb) begin
        read_req = (i == 10);
        valid_in = (i >= 20 && i < 30);
        data_in  = DW'(24'hABC000 + i);
      end
      if (i < DEPTH) begin
        if (valid_out !== 1'b1 || data_out !== DW'(base + i)) begin
          chk("burst_beat_valid", 32'(valid_out), 32'd1);
          chk("burst_beat_data", 32'(data_out), 32'(DW'(base + i)));
        end
        if (valid_out === 1'b1) beats++;
      end else begin
        chk("burst_end_valid", 32'(valid_out), 32'd0);
        chk("burst_end_data", 32'(data_out), 32'd0);
      end
    end
    read_req = 1'b0;
    valid_in = 1'b0;
    chk("burst_len", 32'(beats), 32'd256);
  endtask

  initial begin
    // Reset state
    cyc(5);
    chk("reset_valid", 32'(valid_out), 32'd0);
    chk("reset_data", 32'(data_out), 32'd0);
    rst = 1'b0;

    // 1: full frame 0..255, idle, replay
    write_words(0, 256, 0);
    cyc(5);
    read_burst(0, -1, 0);

    // 2: partial frame ignores read_req; completing write with read_req also ignored
    write_words(24'h1000, 100, 0);
    pulse_req();
    expect_idle("partial_no_output", 8);
    write_words(24'h1000 + 100, 156, 1);
    expect_idle("completion_req_ignored", 4);
    read_burst(24'h1000, -1, 0);

    // 3: overflow words dropped
    write_words(0, 300, 0);
    read_burst(0, -1, 0);

    // 4: back-to-back frames
    write_words(0, 256, 0);
    read_burst(0, -1, 0);
    write_words(24'h100, 256, 0);
    read_burst(24'h100, -1, 0);

    // 5: reset mid-burst, then read_req ignored until a new full frame
    write_words(24'h2000, 256, 0);
    read_burst(24'h2000, 50, 0);
    pulse_req();
    expect_idle("post_reset_req_ignored", 6);
    write_words(24'h3000, 256, 0);
    read_burst(24'h3000, -1, 0);

    // 6: traffic during burst is ignored and not stored
    write_words(24'h4000, 256, 0);
    read_burst(24'h4000, -1, 1);
    write_words(24'h5000, 255, 0);
    pulse_req();
    expect_idle("disturb_not_stored", 4);
    write_words(24'h50FF, 1, 0);
    read_burst(24'h5000, -1, 0);

    cyc(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation exceeded time limit");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1, "timeout");
  end

endmodule
